// File: rtl/cv32e40x_data_req_slice.sv
// rtl/cv32e40x_data_req_slice.sv - two-entry LSU request slice with outstanding-response limiter
package cv32e40x_data_req_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } data_req_t;
endpackage

module cv32e40x_data_req_slice
  import cv32e40x_data_req_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  data_req_t        i_req,
  input  logic             i_valid,
  output logic             o_ready,
  output data_req_t        o_req,
  output logic             o_valid,
  input  logic             i_ready,
  input  logic             i_resp_valid,
  output logic [CNT_W-1:0] o_outstanding,
  output logic             o_resp_err
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  state_t           state_q;
  data_req_t        main_q;
  data_req_t        skid_q;
  logic             ready_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic             blocked;
  logic             accept;
  logic             issue;

  // o_valid depends only on registered state so bus-side inputs never loop back into it
  assign blocked       = (cnt_q == MAX_CNT);
  assign o_valid       = (state_q != EMPTY) && !blocked;
  assign o_ready       = ready_q;
  assign o_req         = main_q;
  assign o_outstanding = cnt_q;
  assign o_resp_err    = err_q;
  assign accept        = i_valid && ready_q;
  assign issue         = o_valid && i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ready_q <= 1'b0;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          ready_q <= 1'b1;
          if (accept) begin
            main_q  <= i_req;
            state_q <= ONE;
          end
        end
        ONE: begin
          ready_q <= 1'b1;
          if (accept && issue) begin
            main_q <= i_req;
          end else if (accept) begin
            skid_q  <= i_req;
            state_q <= TWO;
            ready_q <= 1'b0;
          end else if (issue) begin
            state_q <= EMPTY;
          end
        end
        TWO: begin
          ready_q <= 1'b0;
          if (issue) begin
            main_q  <= skid_q;
            state_q <= ONE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= EMPTY;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // A response racing an issue cancels out; a response with nothing outstanding is an error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (issue && !i_resp_valid) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else if (i_resp_valid && !issue) begin
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end else begin
        err_q <= 1'b1;
      end
    end
  end

endmodule
